// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types for the memory port arbiter:
//   own_t     - owner tag carried alongside each in-flight memory read
//   lock_st_t - D-side lock FSM state
//   STARVE_W  - width of the fixed-priority starvation counter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_OWN_NONE  = 2'd0,
    ARB_OWN_FETCH = 2'd1,
    ARB_OWN_DATA  = 2'd2
  } own_t;

  typedef enum logic {
    ARB_ST_UNLOCKED = 1'b0,
    ARB_ST_LOCKED   = 1'b1
  } lock_st_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester (f_*), the data requester (d_*), the shared
// synchronous memory port (mem_*) and the busy flag.
//   slave  modport : the arbiter's view
//   master modport : the environment's view (requesters + memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_lock;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// arb_tag_pipe
// DEPTH-stage shift register of read-owner tags. Stage DEPTH-1 lines up
// with the cycle in which the memory presents the matching read data.
//   clk    - rising-edge clock
//   reset  - synchronous, active-low clear (all stages -> NONE)
//   i_tag  - tag pushed this cycle (NONE for stores / idle)
//   o_head - tag at the output stage
//   o_any  - 1 when any stage holds a non-NONE tag
module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  own_t i_tag,
  output own_t o_head,
  output logic o_any
);

  own_t r_tag [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= ARB_OWN_NONE;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_head = r_tag[DEPTH-1];

  always_comb begin
    o_any = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_tag[i] != ARB_OWN_NONE) o_any = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous memory port between instruction fetch (F, read
// only) and datapath load/store (D). Grants are combinational from the
// requests and registered state; read ownership is tracked for RD_LAT
// cycles so data returns with a per-requester one-cycle valid pulse.
// D may lock the port across a read-modify-write sequence.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   bus   - mem_port_arbiter_if.slave (F/D handshakes, memory port, busy)
// Build option:
//   OSECPU_ARB_RR_EN defined   -> round-robin arbitration when unlocked
//   OSECPU_ARB_RR_EN undefined -> D-first priority with F starvation guard
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  lock_st_t          r_lock_st, w_lock_nxt;
  logic              w_f_gnt, w_d_gnt;
  logic [ADDR_W-1:0] r_last_addr, w_mem_addr;
  logic [DATA_W-1:0] r_f_rdata, r_d_rdata;
  own_t              w_tag_in, w_head;
  logic              w_any;
  logic              w_f_rvalid, w_d_rvalid;

`ifdef OSECPU_ARB_RR_EN
  // 1 = D won the most recent grant; resets to F so D takes the first tie.
  logic r_last_d, w_last_d_nxt;
`else
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  logic [STARVE_W-1:0] r_starve, w_starve_nxt;
`endif

  // Arbitration and lock FSM next-state
  always_comb begin
    w_f_gnt    = 1'b0;
    w_d_gnt    = 1'b0;
    w_lock_nxt = r_lock_st;
`ifdef OSECPU_ARB_RR_EN
    w_last_d_nxt = r_last_d;
`else
    w_starve_nxt = r_starve;
`endif
    if (reset) begin
      if (r_lock_st == ARB_ST_LOCKED) begin
        w_d_gnt = bus.d_req;
      end else if (bus.f_req && bus.d_req) begin
`ifdef OSECPU_ARB_RR_EN
        w_f_gnt = r_last_d;
        w_d_gnt = !r_last_d;
`else
        w_f_gnt = (r_starve == STARVE_LIM);
        w_d_gnt = !w_f_gnt;
`endif
      end else begin
        w_f_gnt = bus.f_req;
        w_d_gnt = bus.d_req;
      end

      // d_lock is only meaningful on the cycle D is granted.
      if (w_d_gnt)
        w_lock_nxt = bus.d_lock ? ARB_ST_LOCKED : ARB_ST_UNLOCKED;

`ifdef OSECPU_ARB_RR_EN
      if (w_f_gnt) w_last_d_nxt = 1'b0;
      if (w_d_gnt) w_last_d_nxt = 1'b1;
`else
      // Counter is frozen while locked so a long RMW does not force F in.
      if (r_lock_st == ARB_ST_UNLOCKED)
        w_starve_nxt = (bus.f_req && !w_f_gnt) ? r_starve + 1'b1 : '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lock_st   <= ARB_ST_UNLOCKED;
      r_last_addr <= '0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
`ifdef OSECPU_ARB_RR_EN
      r_last_d    <= 1'b0;
`else
      r_starve    <= '0;
`endif
    end else begin
      r_lock_st   <= w_lock_nxt;
      r_last_addr <= w_mem_addr;
      if (w_f_rvalid) r_f_rdata <= bus.mem_rdata;
      if (w_d_rvalid) r_d_rdata <= bus.mem_rdata;
`ifdef OSECPU_ARB_RR_EN
      r_last_d    <= w_last_d_nxt;
`else
      r_starve    <= w_starve_nxt;
`endif
    end
  end

  // Memory drive: address holds the last granted value when idle.
  assign w_mem_addr    = w_f_gnt ? bus.f_addr : (w_d_gnt ? bus.d_addr : r_last_addr);
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_d_gnt & bus.d_we;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.f_gnt     = w_f_gnt;
  assign bus.d_gnt     = w_d_gnt;

  assign w_tag_in = w_f_gnt                ? ARB_OWN_FETCH :
                    (w_d_gnt && !bus.d_we) ? ARB_OWN_DATA  : ARB_OWN_NONE;

  arb_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_tag  (w_tag_in),
    .o_head (w_head),
    .o_any  (w_any)
  );

  // Returns bypass the hold registers so data appears exactly RD_LAT after
  // the grant; a return coinciding with reset is discarded.
  assign w_f_rvalid   = reset && (w_head == ARB_OWN_FETCH);
  assign w_d_rvalid   = reset && (w_head == ARB_OWN_DATA);
  assign bus.f_rvalid = w_f_rvalid;
  assign bus.d_rvalid = w_d_rvalid;
  assign bus.f_rdata  = w_f_rvalid ? bus.mem_rdata : r_f_rdata;
  assign bus.d_rdata  = w_d_rvalid ? bus.mem_rdata : r_d_rdata;
  assign bus.busy     = (r_lock_st == ARB_ST_LOCKED) || w_any;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous Memory port (addr/rdata/wdata/we) between two requesters.
- Requester F: Controller instruction fetch, read-only.
- Requester D: datapath data load/store.
- Arbitrates per cycle, tracks read ownership through the memory read latency, and returns read data with a per-requester valid pulse.
- Supports a D-side lock for atomic read-modify-write sequences.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 32, memory data width
RD_LAT, 1, cycles from address/grant to valid mem_rdata; legal 1..4
STARVE_MAX, 15, consecutive F-denied cycles before F is forced ahead (fixed-priority mode only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; 0 = reset
f_req  in  1  fetch request; held until f_gnt
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch accepted this cycle
f_rvalid  out  1  f_rdata valid (one-cycle pulse)
f_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_lock  in  1  sampled on a D grant; holds the port for D
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  d_rdata valid (one-cycle pulse, loads only)
d_rdata  out  DATA_W  load read data
mem_addr  out  ADDR_W  to Memory
mem_we  out  1  to Memory
mem_wdata  out  DATA_W  to Memory
mem_rdata  in  DATA_W  from Memory
busy  out  1  1 while any read is in flight or lock is held

Behaviour:
- Grant timing:
  - Grants are combinational from the current req and registered arbiter state.
  - At most one gnt per cycle.
  - A request is accepted on the cycle its gnt=1; the requester may change addr/req on the next cycle.
- Memory drive:
  - mem_addr/mem_wdata/mem_we come from the granted requester.
  - mem_we = d_we & d_gnt.
  - With no grant: mem_we=0; mem_addr holds the last granted address.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on a D grant with d_lock=1.
  - LOCKED -> UNLOCKED on the first D grant with d_lock=0.
  - In LOCKED, f_gnt=0 regardless of f_req; D is granted whenever d_req=1.
- Arbitration in UNLOCKED, fixed-priority mode (macro absent):
  - D beats F.
  - A starvation counter (4 bits) increments each cycle f_req=1 & f_gnt=0, and clears on f_gnt or when f_req=0.
  - When it equals STARVE_MAX, F wins the next contention.
  - In LOCKED the starvation counter freezes.
- Read-data return:
  - Each load/fetch grant pushes an owner tag (NONE/FETCH/DATA) into an RD_LAT-deep shift register; stores and idle cycles push NONE.
  - When the tag at the output stage is FETCH: f_rvalid=1, f_rdata=mem_rdata. DATA: d_rvalid=1, d_rdata=mem_rdata.
  - Exactly RD_LAT cycles after gnt; in-order, one return per cycle max.
  - f_rdata/d_rdata hold their last value when rvalid=0.
- busy = LOCKED | any tag != NONE.
- Reset (reset=0 at a rising edge):
  - All tags become NONE; in-flight reads are discarded, with no rvalid afterwards.
  - Lock -> UNLOCKED; starvation counter -> 0.
  - f_rdata/d_rdata/mem_addr -> 0; f_rvalid/d_rvalid/busy -> 0.
  - While reset=0, gnt=0 and mem_we=0.
- Boundary cases:
  - Simultaneous req with no lock: mode rule decides.
  - Grant issued in the same cycle as a return: both proceed (fully pipelined, throughput 1/cycle).
  - d_lock=1 on a store grant still enters LOCKED.

Optional Feature:
OSECPU_ARB_RR_EN
- Defined:
  - UNLOCKED arbitration is round-robin: a 1-bit last-winner register; on contention the requester that did not win last is granted.
  - Last-winner resets to F, so D wins first contention.
  - The starvation counter and STARVE_MAX are unused (counter stays 0).
- Undefined: fixed priority with starvation counter as above.

Decomposition:
- def.v adds `ARB_OWN_NONE 2'd0, `ARB_OWN_FETCH 2'd1, `ARB_OWN_DATA 2'd2, and `ARB_ST_UNLOCKED/`ARB_ST_LOCKED.
- One sub-module, arb_tag_pipe: RD_LAT-deep owner-tag shift register with synchronous active-low clear; outputs the head tag and any-valid.

Test Plan:
1. Reset then F only: f_req=1, f_addr=0x0010 held 3 cycles -> f_gnt=1 each cycle; f_rvalid pulses at cycles +1,+2,+3 with Memory[0x0010]; busy=1 throughout.
2. Contention, fixed mode: f_req and d_req (load 0x0200) high together -> d_gnt first; f_gnt the next cycle; d_rvalid then f_rvalid on consecutive cycles.
3. Starvation, fixed mode: D requests continuously, F requests continuously -> F granted on cycle 16 (STARVE_MAX=15); counter clears after the grant.
4. Lock: D load 0x0300 with d_lock=1, then store 0x0300=0xDEADBEEF with d_lock=0, F requesting throughout -> f_gnt=0 until after the store grant; mem_we=1 only on the store cycle; busy drops after the return.
5. Reset mid-flight: RD_LAT=3, grant F load, assert reset=0 the next cycle for 1 cycle -> no f_rvalid ever; all outputs 0; busy=0.
6. With OSECPU_ARB_RR_EN: both requesting for 6 cycles -> grants alternate D,F,D,F,D,F; six rvalids return in the same order.
